// File: rtl/ped_crossing_ctrl_pkg.sv
// Shared definitions for the pedestrian crossing controller: state
// encodings, reset values of the registered outputs and a small helper.
package ped_crossing_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WALK  = 2'd2,
        S_CLEAR = 2'd3
    } ped_state_t;

    localparam ped_state_t RST_STATE     = S_IDLE;
    localparam logic       RST_WALK      = 1'b0;
    localparam logic       RST_DONT_WALK = 1'b1;
    localparam logic       RST_WAIT      = 1'b0;
    localparam logic       RST_FAULT     = 1'b0;
    // Red starts "already seen" so a red lamp high straight out of reset is not an edge.
    localparam logic       RST_RED_Q     = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ped_crossing_ctrl_timer.sv
// ped_timer: loadable down-counter with a zero flag. Load wins over
// decrement; the count holds at zero instead of wrapping.
module ped_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_reg;

    // Count register: load a new interval or step down toward zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian signal head driven from the car lamps.
// A latched request is served at the start of a car-red phase with a walk
// interval, followed by a flashing don't-walk clearance interval.
// Optional build macro PED_LAMP_CHECK_EN adds a sticky lamp-consistency
// fault that parks the head in don't-walk; without it o_fault is tied low.
module ped_crossing_ctrl
    import ped_crossing_ctrl_pkg::*;
#(
    parameter int WALK  = 4,
    parameter int CLEAR = 6,
    parameter int BLINK = 2
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_yellow,
    input  logic i_green,
    input  logic i_red,
    input  logic i_btn,
    output logic o_walk,
    output logic o_dont_walk,
    output logic o_wait,
    output logic o_fault
);

    localparam int CNT_W   = $clog2(max_int(WALK, CLEAR) + 1);
    localparam int BLINK_W = $clog2(BLINK + 1);
    localparam logic [CNT_W-1:0]   WALK_LOAD  = CNT_W'(WALK - 1);
    localparam logic [CNT_W-1:0]   CLEAR_LOAD = CNT_W'(CLEAR - 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK - 1);

    ped_state_t       state_reg, state_next;
    logic             red_q_reg;
    logic             red_rise;
    logic             pend_reg, pend_next;
    logic             phase_reg, phase_next;
    logic             cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic             blink_load, blink_en, blink_zero;
    logic             walk_reg, walk_next;
    logic             dont_walk_reg, dont_walk_next;
    logic             wait_reg, wait_next;

    assign red_rise = i_red & ~red_q_reg;

`ifdef PED_LAMP_CHECK_EN
    logic fault_reg, fault_next, lamp_bad;

    // Fault detection: more than one car lamp lit, or green while walking.
    always_comb begin
        lamp_bad   = (({1'b0, i_yellow} + {1'b0, i_green} + {1'b0, i_red}) > 2'd1)
                   || (i_green && (state_reg == S_WALK));
        fault_next = fault_reg | lamp_bad;
    end

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fault_reg <= RST_FAULT;
        end else begin
            fault_reg <= fault_next;
        end
    end

    assign o_fault = fault_reg;
`else
    logic unused_lamps;
    assign unused_lamps = i_yellow ^ i_green;
    assign o_fault      = RST_FAULT;
`endif

    // Phase counter: walk length, then clearance length.
    ped_timer #(.W(CNT_W)) u_phase_timer (
        .clk      (clk),
        .rst_n    (i_rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // Blink counter: half-period of the clearance flash.
    ped_timer #(.W(BLINK_W)) u_blink_timer (
        .clk      (clk),
        .rst_n    (i_rst_n),
        .load     (blink_load),
        .load_val (BLINK_LOAD),
        .en       (blink_en),
        .zero     (blink_zero)
    );

    assign cnt_en   = (state_reg == S_WALK) || (state_reg == S_CLEAR);
    assign blink_en = (state_reg == S_CLEAR);

    // Next-state logic, counter loads, flash phase and pending request.
    always_comb begin
        state_next   = state_reg;
        pend_next    = pend_reg;
        phase_next   = phase_reg;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        blink_load   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (i_btn) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (red_rise) begin
                    state_next   = S_WALK;
                    cnt_load     = 1'b1;
                    cnt_load_val = WALK_LOAD;
                end
            end
            S_WALK: begin
                // Walk ends on its own timeout or as soon as car red drops.
                if (cnt_zero || !i_red) begin
                    state_next   = S_CLEAR;
                    cnt_load     = 1'b1;
                    cnt_load_val = CLEAR_LOAD;
                    blink_load   = 1'b1;
                    phase_next   = 1'b1;
                    pend_next    = 1'b0;
                end
            end
            S_CLEAR: begin
                if (i_btn) pend_next = 1'b1;
                if (blink_zero) begin
                    phase_next = ~phase_reg;
                    blink_load = 1'b1;
                end
                if (cnt_zero) begin
                    state_next = (pend_reg || i_btn) ? S_WAIT : S_IDLE;
                    pend_next  = 1'b0;
                end
            end
            default: state_next = S_IDLE;
        endcase
`ifdef PED_LAMP_CHECK_EN
        if (fault_next) begin
            state_next = S_IDLE;
            pend_next  = 1'b0;
            phase_next = 1'b1;
            cnt_load   = 1'b0;
            blink_load = 1'b0;
        end
`endif
    end

    // Output decode from the upcoming state so the lamps are registered.
    always_comb begin
        walk_next      = (state_next == S_WALK);
        dont_walk_next = 1'b1;
        if (state_next == S_WALK)  dont_walk_next = 1'b0;
        if (state_next == S_CLEAR) dont_walk_next = phase_next;
        wait_next      = (state_next == S_WAIT) || ((state_next == S_CLEAR) && pend_next);
    end

    // State, edge detector, flash phase, pending flag and lamp registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= RST_STATE;
            red_q_reg     <= RST_RED_Q;
            pend_reg      <= 1'b0;
            phase_reg     <= 1'b1;
            walk_reg      <= RST_WALK;
            dont_walk_reg <= RST_DONT_WALK;
            wait_reg      <= RST_WAIT;
        end else begin
            state_reg     <= state_next;
            red_q_reg     <= i_red;
            pend_reg      <= pend_next;
            phase_reg     <= phase_next;
            walk_reg      <= walk_next;
            dont_walk_reg <= dont_walk_next;
            wait_reg      <= wait_next;
        end
    end

    assign o_walk      = walk_reg;
    assign o_dont_walk = dont_walk_reg;
    assign o_wait      = wait_reg;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Testbench for ped_crossing_ctrl: directed stimulus with literal expected
// lamp sequences, plus a cycle-level model of the crossing rules that is
// compared against the DUT on every falling clock edge.
module tb_ped_crossing_ctrl;

    localparam int WALK  = 4;
    localparam int CLEAR = 6;
    localparam int BLINK = 2;

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_WALK  = 2;
    localparam int M_CLEAR = 3;

    logic clk      = 1'b0;
    logic i_rst_n  = 1'b0;
    logic i_yellow = 1'b0;
    logic i_green  = 1'b0;
    logic i_red    = 1'b0;
    logic i_btn    = 1'b0;
    logic o_walk, o_dont_walk, o_wait, o_fault;

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    ped_crossing_ctrl #(.WALK(WALK), .CLEAR(CLEAR), .BLINK(BLINK)) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_yellow    (i_yellow),
        .i_green     (i_green),
        .i_red       (i_red),
        .i_btn       (i_btn),
        .o_walk      (o_walk),
        .o_dont_walk (o_dont_walk),
        .o_wait      (o_wait),
        .o_fault     (o_fault)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic ew, input logic edw, input logic ewt);
        chk({tag, "_walk"}, o_walk, ew);
        chk({tag, "_dont_walk"}, o_dont_walk, edw);
        chk({tag, "_wait"}, o_wait, ewt);
    endtask

    // One clock with the given request/red levels; returns just after the edge.
    task automatic cyc(input logic b, input logic r);
        i_btn = b;
        i_red = r;
        @(posedge clk);
        #1;
    endtask

    // Crossing model: mode, walk cycles served, clearance cycle index.
    int   m_mode;
    int   m_w;
    int   m_ci;
    logic m_pend;
    logic m_red_prev;
    logic m_fault;
    logic m_rise;
    logic m_bad;

    always @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_mode     = M_IDLE;
            m_w        = 0;
            m_ci       = 0;
            m_pend     = 1'b0;
            m_red_prev = 1'b1;
            m_fault    = 1'b0;
        end else begin
            m_rise = i_red && !m_red_prev;
            m_bad  = ((int'(i_yellow) + int'(i_green) + int'(i_red)) > 1)
                   || (i_green && (m_mode == M_WALK));
            case (m_mode)
                M_IDLE: if (i_btn) m_mode = M_WAIT;
                M_WAIT: if (m_rise) begin m_mode = M_WALK; m_w = 0; end
                M_WALK: begin
                    m_w++;
                    if ((m_w >= WALK) || !i_red) begin
                        m_mode = M_CLEAR;
                        m_ci   = 0;
                        m_pend = 1'b0;
                    end
                end
                default: begin
                    if (i_btn) m_pend = 1'b1;
                    m_ci++;
                    if (m_ci >= CLEAR) begin
                        m_mode = m_pend ? M_WAIT : M_IDLE;
                        m_pend = 1'b0;
                    end
                end
            endcase
            m_red_prev = i_red;
`ifdef PED_LAMP_CHECK_EN
            if (m_fault || m_bad) begin
                m_fault = 1'b1;
                m_mode  = M_IDLE;
                m_pend  = 1'b0;
            end
`endif
        end
    end

    // Every falling edge: DUT lamps against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_walk", o_walk, m_mode == M_WALK);
            chk("model_dont_walk", o_dont_walk,
                (m_mode == M_WALK) ? 1'b0 :
                (m_mode == M_CLEAR) ? (((m_ci / BLINK) % 2) == 0) : 1'b1);
            chk("model_wait", o_wait, (m_mode == M_WAIT) || ((m_mode == M_CLEAR) && m_pend));
            chk("model_fault", o_fault, m_fault);
        end
    end

    initial begin
        logic [9:0] e_walk;
        logic [9:0] e_dw;
        logic [9:0] e_wait4;
        logic [5:0] e_clr;
        e_walk  = 10'b0000001111;
        e_dw    = 10'b1100110000;
        e_wait4 = 10'b1111000000;
        e_clr   = 6'b110011;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk3("reset", 1'b0, 1'b1, 1'b0);
        chk("reset_fault", o_fault, 1'b0);
        i_rst_n = 1'b1;
        cmp_en  = 1'b1;

        // Idle with car red low: steady don't-walk.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0);
            chk3("idle", 1'b0, 1'b1, 1'b0);
        end

        // One-cycle press, then ten cycles of car red.
        cyc(1'b1, 1'b0);
        chk3("req", 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        chk3("req_hold", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1);
            chk3("red10", e_walk[i], e_dw[i], 1'b0);
        end
        cyc(1'b0, 1'b0);
        chk3("back_idle", 1'b0, 1'b1, 1'b0);

        // Red lasting only two cycles truncates walk to two cycles.
        cyc(1'b1, 1'b0);
        chk3("trunc_req", 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        chk3("trunc_walk0", 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk3("trunc_walk1", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0);
            chk3("trunc_clr", 1'b0, e_clr[i], 1'b0);
        end
        cyc(1'b0, 1'b0);
        chk3("trunc_idle", 1'b0, 1'b1, 1'b0);

        // Press during clearance re-queues the request.
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(i == 6, 1'b1);
            chk3("clr_press", e_walk[i], e_dw[i], e_wait4[i]);
        end
        cyc(1'b0, 1'b0);
        chk3("requeued", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1);
            chk("rewalk", o_walk, i < 4);
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
        chk3("rewalk_idle", 1'b0, 1'b1, 1'b0);

        // Asynchronous reset pulse in the middle of a walk.
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk("pre_rst_walk", o_walk, 1'b1);
        #1 i_rst_n = 1'b0;
        #1 chk3("async_rst", 1'b0, 1'b1, 1'b0);
        #4 i_rst_n = 1'b1;
        cyc(1'b0, 1'b1);
        chk3("after_rst", 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);

`ifdef PED_LAMP_CHECK_EN
        // Red and green together trip the sticky fault.
        i_green = 1'b1;
        cyc(1'b0, 1'b1);
        i_green = 1'b0;
        chk("fault_set", o_fault, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1);
            chk3("fault_hold", 1'b0, 1'b1, 1'b0);
            chk("fault_sticky", o_fault, 1'b1);
        end
`endif

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
